// File: rtl/eprisc_bus_pkg.sv
// eprisc_bus_pkg: shared types and defaults for epRISC bus initiators.
package eprisc_bus_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;
    localparam int RD_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WAIT,
        WRITE,
        FINISH
    } dmaState_t;

    function automatic logic isBusPhase(input dmaState_t s);
        return (s == READ) || (s == WAIT) || (s == WRITE);
    endfunction

endpackage

// File: rtl/eprisc_bus_tristate.sv
// eprisc_bus_tristate: drives the shared address/data/strobe lines only while enabled.
module eprisc_bus_tristate #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              iEn,
    input  logic              iDataEn,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iData,
    input  logic              iWrite,
    output tri   [ADDR_W-1:0] oAddr,
    output tri                oWrite,
    inout  tri   [DATA_W-1:0] bData
);

    assign oAddr  = iEn ? iAddr : 'z;
    assign oWrite = iEn ? iWrite : 1'bz;
    assign bData  = (iEn && iDataEn) ? iData : 'z;

endmodule

// File: rtl/eprisc_bus_dma.sv
// eprisc_bus_dma: block-copy engine acting as a second epRISC bus initiator.
// One word per READ/WAIT/WRITE pass; losing the grant restarts the current word.
module eprisc_bus_dma
    import eprisc_bus_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iSrc,
    input  logic [ADDR_W-1:0] iDst,
    input  logic [CNT_W-1:0]  iCount,
    output logic              oBusy,
    output logic              oDone,
    output logic              oBusReq,
    input  logic              iBusGnt,
    output tri   [ADDR_W-1:0] oAddr,
    inout  tri   [DATA_W-1:0] bData,
    output tri                oWrite
);

    dmaState_t         state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] dataReg;
    logic              own;
    logic              inWrite;

    // Ownership follows the grant combinationally so a revoked grant frees the bus at once.
    assign own     = oBusReq && iBusGnt && isBusPhase(state);
    assign inWrite = (state == WRITE);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= IDLE;
            src     <= '0;
            dst     <= '0;
            count   <= '0;
            dataReg <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oBusReq <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart && iCount != '0) begin
                        src     <= iSrc;
                        dst     <= iDst;
                        count   <= iCount;
                        state   <= REQ;
                        oBusy   <= 1'b1;
                        oBusReq <= 1'b1;
                    end else if (iStart) begin
                        state <= FINISH;
                        oBusy <= 1'b1;
                        oDone <= 1'b1;
                    end
                end
                REQ: state <= iBusGnt ? READ : REQ;
                READ: state <= iBusGnt ? WAIT : REQ;
                WAIT: begin
                    if (iBusGnt) begin
                        dataReg <= bData;
                        state   <= WRITE;
                    end else begin
                        state <= REQ;
                    end
                end
                WRITE: begin
                    if (!iBusGnt) begin
                        state <= REQ;
                    end else begin
                        src   <= src + ADDR_W'(1);
                        dst   <= dst + ADDR_W'(1);
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state   <= FINISH;
                            oBusReq <= 1'b0;
                            oDone   <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    eprisc_bus_tristate #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) uTri (
        .iEn    (own),
        .iDataEn(inWrite),
        .iAddr  (inWrite ? dst : src),
        .iData  (dataReg),
        .iWrite (inWrite),
        .oAddr  (oAddr),
        .oWrite (oWrite),
        .bData  (bData)
    );

endmodule

// File: tb/tb_eprisc_bus_dma.sv
// tb_eprisc_bus_dma: bus DMA against a registered ROM/RAM responder and an array-level copy model.
module tb_eprisc_bus_dma;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic        iBusGnt;
    logic [31:0] iSrc;
    logic [31:0] iDst;
    logic [15:0] iCount;
    logic        oBusy;
    logic        oDone;
    logic        oBusReq;
    tri1  [31:0] addrBus;
    tri0         writeBus;
    tri   [31:0] dataBus;

    bit   [31:0] rom  [256];
    bit   [31:0] ram  [256];
    bit   [31:0] mRam [256];
    logic [31:0] romQ;
    int          writeCnt = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 iClk = ~iClk;

    eprisc_bus_dma dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (iStart),
        .iSrc   (iSrc),
        .iDst   (iDst),
        .iCount (iCount),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oBusReq(oBusReq),
        .iBusGnt(iBusGnt),
        .oAddr  (addrBus),
        .bData  (dataBus),
        .oWrite (writeBus)
    );

    // Responders decode the low 8 address bits; ROM read data is registered one edge after the address.
    assign dataBus = writeBus ? 'z : romQ;

    always @(posedge iClk) begin
        romQ <= rom[addrBus[7:0]];
        if (writeBus) begin
            ram[addrBus[7:0]] <= dataBus;
            writeCnt <= writeCnt + 1;
        end
    end

    function automatic void modelCopy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) mRam[8'(d + 32'(i))] = rom[8'(s + 32'(i))];
    endfunction

    function automatic int ramDiffs();
        int c = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== mRam[i]) c++;
        return c;
    endfunction

    task automatic startCopy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge iClk);
        iSrc = s;
        iDst = d;
        iCount = n;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic waitDone(input int fromCycle, output int doneAt);
        doneAt = -1;
        for (int k = fromCycle; k < fromCycle + 80; k++) begin
            if (oDone === 1'b1) begin
                doneAt = k;
                return;
            end
            @(negedge iClk);
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        iStart = 1'b0;
        iBusGnt = 1'b0;
        iSrc = '0;
        iDst = '0;
        iCount = '0;
        repeat (2) @(negedge iClk);
        checks++;
        if ({oBusy, oDone, oBusReq} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags busy/done/req=%b expected 000", {oBusy, oDone, oBusReq});
        end
        checks++;
        if (addrBus !== 32'hFFFFFFFF || writeBus !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus addr=%h write=%b expected undriven", addrBus, writeBus);
        end
        iRst = 1'b0;
    endtask

    task automatic test_basic();
        int doneAt;
        int w0;
        iBusGnt = 1'b1;
        w0 = writeCnt;
        for (int i = 0; i < 4; i++) rom[i] = 32'hA0 + 32'(i);
        checks++;
        if (oBusReq !== 1'b0) begin
            errors++;
            $display("FAIL basic_req_idle req=%b expected 0", oBusReq);
        end
        startCopy(32'h0, 32'h100, 16'd4);
        checks++;
        if (oBusReq !== 1'b1 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL basic_req_rise req=%b busy=%b expected 1 1", oBusReq, oBusy);
        end
        waitDone(1, doneAt);
        modelCopy(32'h0, 32'h100, 4);
        checks++;
        if (doneAt != 14) begin
            errors++;
            $display("FAIL basic_done_cycle got=%0d expected 14", doneAt);
        end
        checks++;
        if (writeCnt - w0 != 4) begin
            errors++;
            $display("FAIL basic_write_pulses got=%0d expected 4", writeCnt - w0);
        end
        checks++;
        if (ramDiffs() != 0) begin
            errors++;
            $display("FAIL basic_ram diffs=%0d ram[0]=%h expected %h", ramDiffs(), ram[0], mRam[0]);
        end
        @(negedge iClk);
        checks++;
        if (oBusy !== 1'b0 || oDone !== 1'b0) begin
            errors++;
            $display("FAIL basic_after busy=%b done=%b expected 0 0", oBusy, oDone);
        end
    endtask

    task automatic test_zero();
        int w0;
        int reqSeen;
        iBusGnt = 1'b1;
        w0 = writeCnt;
        reqSeen = 0;
        startCopy($urandom, $urandom, 16'd0);
        checks++;
        if (oDone !== 1'b1 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done done=%b busy=%b expected 1 1", oDone, oBusy);
        end
        for (int k = 0; k < 4; k++) begin
            if (oBusReq !== 1'b0) reqSeen++;
            @(negedge iClk);
        end
        checks++;
        if (reqSeen != 0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
            errors++;
            $display("FAIL zero_after reqCycles=%0d busy=%b done=%b expected 0 0 0", reqSeen, oBusy, oDone);
        end
        checks++;
        if (writeCnt != w0 || ramDiffs() != 0) begin
            errors++;
            $display("FAIL zero_ram writes=%0d diffs=%0d expected 0 0", writeCnt - w0, ramDiffs());
        end
    endtask

    task automatic test_random();
        int doneAt;
        int w0;
        logic [31:0] s;
        logic [31:0] d;
        int n;
        iBusGnt = 1'b1;
        for (int t = 0; t < 5; t++) begin
            s = $urandom;
            d = $urandom;
            n = $urandom_range(1, 7);
            w0 = writeCnt;
            startCopy(s, d, 16'(n));
            waitDone(1, doneAt);
            modelCopy(s, d, n);
            checks++;
            if (doneAt != 3 * n + 2 || writeCnt - w0 != n || ramDiffs() != 0) begin
                errors++;
                $display("FAIL random_%0d done=%0d writes=%0d diffs=%0d expected done=%0d writes=%0d diffs=0",
                         t, doneAt, writeCnt - w0, ramDiffs(), 3 * n + 2, n);
            end
        end
    endtask

    task automatic test_grant_wait();
        int doneAt;
        int bad;
        bad = 0;
        iBusGnt = 1'b0;
        startCopy(32'h10, 32'h40, 16'd2);
        for (int k = 1; k < 5; k++) begin
            if (addrBus !== 32'hFFFFFFFF || writeBus !== 1'b0 || oBusReq !== 1'b1) bad++;
            @(negedge iClk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gwait_idle badCycles=%0d expected 0", bad);
        end
        iBusGnt = 1'b1;
        waitDone(5, doneAt);
        modelCopy(32'h10, 32'h40, 2);
        checks++;
        if (doneAt != 12) begin
            errors++;
            $display("FAIL gwait_done_cycle got=%0d expected 12", doneAt);
        end
        checks++;
        if (ramDiffs() != 0) begin
            errors++;
            $display("FAIL gwait_ram diffs=%0d expected 0", ramDiffs());
        end
    endtask

    task automatic test_grant_drop();
        int doneAt;
        int w0;
        iBusGnt = 1'b1;
        w0 = writeCnt;
        startCopy(32'h20, 32'h60, 16'd3);
        repeat (2) @(negedge iClk);
        iBusGnt = 1'b0;
        #1;
        checks++;
        if (addrBus !== 32'hFFFFFFFF || writeBus !== 1'b0) begin
            errors++;
            $display("FAIL gdrop_release addr=%h write=%b expected undriven", addrBus, writeBus);
        end
        @(negedge iClk);
        checks++;
        if (addrBus !== 32'hFFFFFFFF || writeBus !== 1'b0 || oBusReq !== 1'b1) begin
            errors++;
            $display("FAIL gdrop_hold addr=%h write=%b req=%b expected undriven and req 1", addrBus, writeBus, oBusReq);
        end
        @(negedge iClk);
        iBusGnt = 1'b1;
        waitDone(5, doneAt);
        modelCopy(32'h20, 32'h60, 3);
        checks++;
        if (doneAt != 15 || writeCnt - w0 != 3 || ramDiffs() != 0) begin
            errors++;
            $display("FAIL gdrop_result done=%0d writes=%0d diffs=%0d expected 15 3 0", doneAt, writeCnt - w0, ramDiffs());
        end
    endtask

    task automatic test_wrap();
        int doneAt;
        iBusGnt = 1'b1;
        startCopy(32'hFFFFFFFF, 32'h80, 16'd2);
        repeat (4) @(negedge iClk);
        checks++;
        if (addrBus !== 32'h0 || writeBus !== 1'b0) begin
            errors++;
            $display("FAIL wrap_addr addr=%h write=%b expected 00000000 0", addrBus, writeBus);
        end
        waitDone(5, doneAt);
        modelCopy(32'hFFFFFFFF, 32'h80, 2);
        checks++;
        if (doneAt != 8 || ramDiffs() != 0) begin
            errors++;
            $display("FAIL wrap_result done=%0d diffs=%0d expected 8 0", doneAt, ramDiffs());
        end
    endtask

    task automatic test_reset_mid();
        int doneAt;
        int w0;
        int doneSeen;
        iBusGnt = 1'b1;
        w0 = writeCnt;
        doneSeen = 0;
        startCopy(32'h30, 32'hA0, 16'd4);
        repeat (6) @(negedge iClk);
        checks++;
        if (writeBus !== 1'b1 || addrBus !== 32'hA1) begin
            errors++;
            $display("FAIL rmid_in_write write=%b addr=%h expected 1 000000a1", writeBus, addrBus);
        end
        iRst = 1'b1;
        #1;
        checks++;
        if (addrBus !== 32'hFFFFFFFF || writeBus !== 1'b0 || oBusy !== 1'b0 || oBusReq !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release addr=%h write=%b busy=%b req=%b expected undriven 0 0", addrBus, writeBus, oBusy, oBusReq);
        end
        @(negedge iClk);
        iRst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (oDone !== 1'b0) doneSeen++;
            @(negedge iClk);
        end
        modelCopy(32'h30, 32'hA0, 1);
        checks++;
        if (doneSeen != 0 || writeCnt - w0 != 1 || ramDiffs() != 0) begin
            errors++;
            $display("FAIL rmid_abandon done=%0d writes=%0d diffs=%0d expected 0 1 0", doneSeen, writeCnt - w0, ramDiffs());
        end
        startCopy(32'h30, 32'hA0, 16'd4);
        waitDone(1, doneAt);
        modelCopy(32'h30, 32'hA0, 4);
        checks++;
        if (doneAt != 14 || ramDiffs() != 0) begin
            errors++;
            $display("FAIL rmid_restart done=%0d diffs=%0d expected 14 0", doneAt, ramDiffs());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        test_reset();
        test_basic();
        test_zero();
        test_random();
        test_grant_wait();
        test_grant_drop();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
